// File: rtl/fpu_add_issuer.sv
// Caller-side issuer for the FP adder controller: queues operand pairs and runs the level handshake.
// Optional watchdog in WAIT_RESP is enabled by defining FPU_ADD_ISSUER_TIMEOUT_EN.
module fpu_add_issuer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Op_valid,
  output logic        Op_ready,
  input  logic [31:0] Op_a,
  input  logic [31:0] Op_b,
  input  logic [2:0]  Op_mode,
  output logic        Res_valid,
  input  logic        Res_ready,
  output logic [31:0] Res_data,
  output logic [2:0]  Res_exc,
  output logic        Res_timeout,
  output logic [31:0] Datain1,
  output logic [31:0] Datain2,
  output logic        Data_valid,
  output logic [2:0]  Mode,
  output logic [4:0]  Debug,
  input  logic [31:0] Dataout,
  input  logic        Dataout_valid,
  input  logic [2:0]  Exc,
  output logic        Busy,
  output logic [15:0] Issue_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fpu_add_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT_RESP, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_a_q [DEPTH];
  logic [31:0]     mem_a_d [DEPTH];
  logic [31:0]     mem_b_q [DEPTH];
  logic [31:0]     mem_b_d [DEPTH];
  logic [2:0]      mem_m_q [DEPTH];
  logic [2:0]      mem_m_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            nonempty_q, nonempty_d;
  logic [31:0]     datain1_q, datain1_d;
  logic [31:0]     datain2_q, datain2_d;
  logic [2:0]      mode_q, mode_d;
  logic            data_valid_q, data_valid_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_data_q, res_data_d;
  logic [2:0]      res_exc_q, res_exc_d;
  logic [15:0]     issue_cnt_q, issue_cnt_d;
  logic            full, push, issue;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   timer_q, timer_d;
  logic            res_timeout_q, res_timeout_d;
`endif

  // nonempty_q lags count_q by one cycle so a fresh entry is issued two edges after acceptance;
  // the lag never matters after a pop because the FSM spends at least two cycles outside IDLE.
  always_comb begin
    full       = (count_q == FULL_CNT);
    push       = Op_valid && !full;
    issue      = (state_q == IDLE) && nonempty_q && !Dataout_valid && !res_valid_q;
    nonempty_d = (count_q != '0);
    wr_ptr_d   = push  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(issue);
    mem_a_d    = mem_a_q;
    mem_b_d    = mem_b_q;
    mem_m_d    = mem_m_q;
    if (push) begin
      mem_a_d[wr_ptr_q] = Op_a;
      mem_b_d[wr_ptr_q] = Op_b;
      mem_m_d[wr_ptr_q] = Op_mode;
    end
  end

  always_comb begin
    state_d       = state_q;
    datain1_d     = datain1_q;
    datain2_d     = datain2_q;
    mode_d        = mode_q;
    data_valid_d  = data_valid_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_exc_d     = res_exc_q;
    issue_cnt_d   = issue_cnt_q;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
    timer_d       = timer_q;
    res_timeout_d = res_timeout_q;
`endif
    if (res_valid_q && Res_ready) begin
      res_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d      = WAIT_RESP;
          datain1_d    = mem_a_q[rd_ptr_q];
          datain2_d    = mem_b_q[rd_ptr_q];
          mode_d       = mem_m_q[rd_ptr_q];
          data_valid_d = 1'b1;
          issue_cnt_d  = issue_cnt_q + 16'd1;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
          timer_d      = '0;
`endif
        end
      end
      WAIT_RESP: begin
        if (Dataout_valid) begin
          state_d       = DRAIN;
          data_valid_d  = 1'b0;
          res_valid_d   = 1'b1;
          res_data_d    = Dataout;
          res_exc_d     = Exc;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog result is a quiet NaN; a late response pulse is absorbed in DRAIN.
          state_d       = DRAIN;
          data_valid_d  = 1'b0;
          res_valid_d   = 1'b1;
          res_data_d    = 32'h7FC00000;
          res_exc_d     = 3'b000;
          res_timeout_d = 1'b1;
        end else begin
          timer_d       = timer_q + TW'(1);
`endif
        end
      end
      DRAIN: begin
        if (!Dataout_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      nonempty_q    <= 1'b0;
      datain1_q     <= '0;
      datain2_q     <= '0;
      mode_q        <= '0;
      data_valid_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_exc_q     <= '0;
      issue_cnt_q   <= '0;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
      timer_q       <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      nonempty_q    <= nonempty_d;
      datain1_q     <= datain1_d;
      datain2_q     <= datain2_d;
      mode_q        <= mode_d;
      data_valid_q  <= data_valid_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_exc_q     <= res_exc_d;
      issue_cnt_q   <= issue_cnt_d;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
      timer_q       <= timer_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
    mem_m_q <= mem_m_d;
  end

  assign Op_ready    = !full;
  assign Res_valid   = res_valid_q;
  assign Res_data    = res_data_q;
  assign Res_exc     = res_exc_q;
  assign Datain1     = datain1_q;
  assign Datain2     = datain2_q;
  assign Data_valid  = data_valid_q;
  assign Mode        = mode_q;
  assign Debug       = 5'b0;
  assign Busy        = (count_q != '0) || (state_q != IDLE);
  assign Issue_count = issue_cnt_q;
`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
  assign Res_timeout = res_timeout_q;
`else
  assign Res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_add_issuer.sv
// Self-checking bench for fpu_add_issuer: behavioural adder responder plus in-order result scoreboard.
// Define FPU_ADD_ISSUER_TIMEOUT_EN to also exercise the watchdog path.
module tb_fpu_add_issuer;

`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Op_valid;
  logic        Op_ready;
  logic [31:0] Op_a;
  logic [31:0] Op_b;
  logic [2:0]  Op_mode;
  logic        Res_valid;
  logic        Res_ready;
  logic [31:0] Res_data;
  logic [2:0]  Res_exc;
  logic        Res_timeout;
  logic [31:0] Datain1;
  logic [31:0] Datain2;
  logic        Data_valid;
  logic [2:0]  Mode;
  logic [4:0]  Debug;
  logic [31:0] Dataout;
  logic        Dataout_valid;
  logic [2:0]  Exc;
  logic        Busy;
  logic [15:0] Issue_count;

  always #5 CLK = ~CLK;

  fpu_add_issuer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .CLK(CLK), .RST(RST),
    .Op_valid(Op_valid), .Op_ready(Op_ready), .Op_a(Op_a), .Op_b(Op_b), .Op_mode(Op_mode),
    .Res_valid(Res_valid), .Res_ready(Res_ready), .Res_data(Res_data), .Res_exc(Res_exc),
    .Res_timeout(Res_timeout),
    .Datain1(Datain1), .Datain2(Datain2), .Data_valid(Data_valid), .Mode(Mode), .Debug(Debug),
    .Dataout(Dataout), .Dataout_valid(Dataout_valid), .Exc(Exc),
    .Busy(Busy), .Issue_count(Issue_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  exc;
    logic        to;
  } res_t;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   accepted    = 0;
  int   resp_lat    = 0;
  int   resp_cnt    = 0;
  bit   resp_en     = 1'b0;
  bit   resp_hold   = 1'b0;

  // Stand-in for the adder controller: three real FP sums, otherwise an arbitrary mixing function.
  function automatic res_t adderModel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    res_t r;
    r.to  = 1'b0;
    r.exc = 3'b000;
    if (a == 32'h40300000 && b == 32'h40B00000)      r.data = 32'h41040000;
    else if (a == 32'hC0300000 && b == 32'h40B00000) r.data = 32'h40300000;
    else if (a == 32'h40300000 && b == 32'hC0B00000) r.data = 32'hC0300000;
    else begin
      r.data = a + b + {29'd0, m};
      r.exc  = m ^ a[2:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    Op_valid = v;
    Op_a     = a;
    Op_b     = b;
    Op_mode  = m;
  endtask

  // One clock: score the result/operand handshakes, advance, then let the responder react.
  task automatic stepCycle();
    logic pre_dv, pre_dov, pre_rv;
    res_t e;
    res_t r;
    pre_dv  = Data_valid;
    pre_dov = Dataout_valid;
    pre_rv  = Res_valid;
    if (Res_valid && Res_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 32'(Res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("res_data", Res_data, e.data);
        checkOutput("res_exc", 32'(Res_exc), 32'(e.exc));
        checkOutput("res_timeout", 32'(Res_timeout), 32'(e.to));
      end
    end
    if (Op_valid && Op_ready && !RST) begin
      exp_q.push_back(adderModel(Op_a, Op_b, Op_mode));
      accepted++;
    end
    @(posedge CLK);
    #1;
    if (!pre_dv && Data_valid) begin
      checkOutput("issue_gate", 32'({pre_dov, pre_rv}), 32'd0);
    end
    if (resp_hold) begin
      Dataout_valid = 1'b1;
    end else if (Dataout_valid) begin
      if (!Data_valid) Dataout_valid = 1'b0;
    end else if (Data_valid && resp_en) begin
      if (resp_cnt >= resp_lat) begin
        r             = adderModel(Datain1, Datain2, Mode);
        Dataout       = r.data;
        Exc           = r.exc;
        Dataout_valid = 1'b1;
        resp_cnt      = 0;
      end else begin
        resp_cnt++;
      end
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || Busy || Res_valid) && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int sent;
    int pre;
    int n;
    int acc0;
    RST           = 1'b1;
    Res_ready     = 1'b0;
    Dataout       = '0;
    Dataout_valid = 1'b0;
    Exc           = '0;
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    stepCycle();

    // Reset state
    checkOutput("rst_op_ready", 32'(Op_ready), 32'd1);
    checkOutput("rst_data_valid", 32'(Data_valid), 32'd0);
    checkOutput("rst_res_valid", 32'(Res_valid), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_issue_cnt", 32'(Issue_count), 32'd0);
    checkOutput("rst_debug", 32'(Debug), 32'd0);
    checkOutput("rst_res_timeout", 32'(Res_timeout), 32'd0);
    checkOutput("rst_datain1", Datain1, 32'd0);
    checkOutput("rst_res_data", Res_data, 32'd0);
    RST = 1'b0;

    // 2.75 + 5.5 with two-edge issue latency
    resp_en   = 1'b1;
    resp_lat  = 2;
    Res_ready = 1'b1;
    applyStimulus(1'b1, 32'h40300000, 32'h40B00000, 3'd1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("t1_dv_edge0", 32'(Data_valid), 32'd0);
    checkOutput("t1_busy", 32'(Busy), 32'd1);
    stepCycle();
    checkOutput("t1_dv_edge1", 32'(Data_valid), 32'd0);
    stepCycle();
    checkOutput("t1_dv_edge2", 32'(Data_valid), 32'd1);
    checkOutput("t1_datain1", Datain1, 32'h40300000);
    checkOutput("t1_datain2", Datain2, 32'h40B00000);
    checkOutput("t1_mode", 32'(Mode), 32'd1);
    checkOutput("t1_issue_cnt", 32'(Issue_count), 32'd1);
    waitIdle("t1_done", 50);

    // Back-to-back pairs, results in order
    applyStimulus(1'b1, 32'hC0300000, 32'h40B00000, 3'd0);
    stepCycle();
    applyStimulus(1'b1, 32'h40300000, 32'hC0B00000, 3'd0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    waitIdle("t2_done", 80);
    checkOutput("t2_issue_cnt", 32'(Issue_count), 32'd3);

    // Backpressure: five pairs with results held
    Res_ready = 1'b0;
    resp_lat  = 1;
    acc0      = accepted;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      stepCycle();
    end
    checkOutput("t3_accepted", 32'(accepted - acc0), 32'd5);
    checkOutput("t3_op_ready_full", 32'(Op_ready), 32'd0);
    applyStimulus(1'b1, $urandom, $urandom, 3'd5);
    repeat (10) stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("t3_accepted_full", 32'(accepted - acc0), 32'd5);
    checkOutput("t3_res_valid", 32'(Res_valid), 32'd1);
    checkOutput("t3_dv_low", 32'(Data_valid), 32'd0);
    checkOutput("t3_issue_cnt_held", 32'(Issue_count), 32'd4);
    checkOutput("t3_busy", 32'(Busy), 32'd1);
    Res_ready = 1'b1;
    waitIdle("t3_done", 200);
    checkOutput("t3_issue_cnt", 32'(Issue_count), 32'd8);

    // Dataout_valid stuck high at idle blocks issue
    Dataout_valid = 1'b1;
    resp_hold     = 1'b1;
    applyStimulus(1'b1, 32'h12345678, 32'h0F0F0F0F, 3'd3);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    repeat (6) stepCycle();
    checkOutput("t4_blocked_dv", 32'(Data_valid), 32'd0);
    checkOutput("t4_blocked_cnt", 32'(Issue_count), 32'd8);
    resp_hold     = 1'b0;
    Dataout_valid = 1'b0;
    resp_cnt      = 0;
    stepCycle();
    checkOutput("t4_issue_next", 32'(Data_valid), 32'd1);
    checkOutput("t4_issue_cnt", 32'(Issue_count), 32'd9);
    waitIdle("t4_done", 50);

`ifdef FPU_ADD_ISSUER_TIMEOUT_EN
    // Silent responder trips the watchdog
    resp_en = 1'b0;
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 3'd2);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    exp_q[exp_q.size() - 1] = '{32'h7FC00000, 3'b000, 1'b1};
    stepCycle();
    stepCycle();
    checkOutput("t5_issued", 32'(Data_valid), 32'd1);
    repeat (7) stepCycle();
    checkOutput("t5_still_waiting", 32'(Data_valid), 32'd1);
    checkOutput("t5_no_result_yet", 32'(Res_valid), 32'd0);
    stepCycle();
    checkOutput("t5_dv_dropped", 32'(Data_valid), 32'd0);
    checkOutput("t5_res_valid", 32'(Res_valid), 32'd1);
    checkOutput("t5_res_timeout", 32'(Res_timeout), 32'd1);
    checkOutput("t5_res_data", Res_data, 32'h7FC00000);
    waitIdle("t5_done", 50);
    resp_en = 1'b1;
`endif

    // Reset while waiting with two entries still queued
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      stepCycle();
    end
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    stepCycle();
    checkOutput("t6_pre_dv", 32'(Data_valid), 32'd1);
    checkOutput("t6_pre_op_ready", 32'(Op_ready), 32'd1);
    RST = 1'b1;
    stepCycle();
    RST = 1'b0;
    exp_q.delete();
    resp_cnt = 0;
    checkOutput("t6_dv", 32'(Data_valid), 32'd0);
    checkOutput("t6_busy", 32'(Busy), 32'd0);
    checkOutput("t6_op_ready", 32'(Op_ready), 32'd1);
    checkOutput("t6_issue_cnt", 32'(Issue_count), 32'd0);
    checkOutput("t6_res_valid", 32'(Res_valid), 32'd0);

    // Random traffic against the scoreboard
    resp_en = 1'b1;
    sent    = 0;
    n       = 0;
    while (sent < 30 && n < 3000) begin
      Res_ready = 1'($urandom_range(0, 1));
      resp_lat  = $urandom_range(0, 4);
      if ($urandom_range(0, 2) != 0)
        applyStimulus(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      else
        applyStimulus(1'b0, '0, '0, '0);
      pre = accepted;
      stepCycle();
      sent += accepted - pre;
      n++;
    end
    applyStimulus(1'b0, '0, '0, '0);
    Res_ready = 1'b1;
    waitIdle("t7_done", 600);
    checkOutput("t7_sent", 32'(sent), 32'd30);
    checkOutput("t7_issue_cnt", 32'(Issue_count), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_add_issuer.md
Name: fpu_add_issuer

Overview:
- Caller-side initiator for the FP adder controller's caller interface (Datain1/Datain2/Data_valid -> Dataout/Dataout_valid/Exc).
- Buffers operand pairs in a small FIFO and issues them one at a time under the level handshake.
- Captures each result and exception code and presents it on a valid/ready result port.
- Sits between the datapath sequencer and the adder controller, and replaces bench-style task driving in the integrated FPU.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 64, watchdog limit in WAIT_RESP; used only with the optional feature

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
Op_valid  in  1  operand pair offered
Op_ready  out  1  FIFO not full
Op_a  in  32  IEEE-754 single operand 1
Op_b  in  32  IEEE-754 single operand 2
Op_mode  in  3  mode forwarded to controller
Res_valid  out  1  result held
Res_ready  in  1  result consumed
Res_data  out  32  captured sum
Res_exc  out  3  captured exception code
Res_timeout  out  1  result produced by watchdog
Datain1  out  32  to controller
Datain2  out  32  to controller
Data_valid  out  1  request level to controller
Mode  out  3  to controller
Debug  out  5  to controller, constant 5'b0
Dataout  in  32  controller result
Dataout_valid  in  1  controller result level
Exc  in  3  controller exception code
Busy  out  1  FIFO non-empty or state != IDLE
Issue_count  out  16  requests issued, wraps 16'hFFFF->0

Behaviour:
- Reset state:
  - All outputs 0 and FIFO empty, except Op_ready, which is 1 (FIFO empty).
  - State IDLE; Issue_count 0.
  - RST asserted mid-operation: Data_valid deasserts at that edge and FIFO contents are discarded. The controller shares RST.
- FIFO:
  - Push when Op_valid && Op_ready. Op_ready = !full, taken from registered count.
  - Push at full is ignored, even if a pop occurs in the same cycle.
  - A pushed entry is poppable from the next cycle; there is no same-cycle bypass.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT_RESP, DRAIN.
  - IDLE -> WAIT_RESP when all of: FIFO non-empty, Dataout_valid==0, Res_valid==0.
    - On that edge: load Datain1/Datain2/Mode from the FIFO head, pop, set Data_valid<=1, Issue_count+1.
  - WAIT_RESP -> DRAIN on the first sampled Dataout_valid==1.
    - On that edge: Res_data<=Dataout, Res_exc<=Exc, Res_timeout<=0, Res_valid<=1, Data_valid<=0.
  - DRAIN -> IDLE on the first sampled Dataout_valid==0. Back-to-back issue is allowed in the cycle after the return to IDLE.
  - Datain1/Datain2/Mode hold their values until the next issue.
- Latency:
  - Op accepted at edge t -> Data_valid high after edge t+2, when the FIFO was empty and the FSM idle.
  - Dataout_valid sampled high at edge r -> Res_valid high after edge r.
- Result port:
  - Res_valid/Res_data/Res_exc/Res_timeout hold stable until Res_valid && Res_ready; Res_valid clears on that edge.
  - Only one request is in flight at a time. No new issue while Res_valid==1 (backpressure).
- Ignored inputs:
  - Dataout_valid in IDLE has no effect beyond blocking issue.
  - Dataout_valid already high at entry to IDLE blocks issue until it drops.

Optional Feature:
- Macro FPU_ADD_ISSUER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_RESP.
  - If it reaches TIMEOUT_CYCLES with Dataout_valid never sampled high, then on that edge: Data_valid<=0, Res_data<=32'h7FC00000, Res_exc<=3'b000, Res_timeout<=1, Res_valid<=1, and the FSM goes to DRAIN.
  - A late Dataout_valid pulse is absorbed by DRAIN.
- Undefined:
  - No counter; WAIT_RESP waits indefinitely.
  - Res_timeout is tied 0; the port remains present.

Test Plan:
- Push Op_a=32'h40300000, Op_b=32'h40B00000 (2.75+5.5) with the real controller+adder -> Data_valid high 2 cycles after accept; Res_valid with Res_data=32'h41040000, Res_timeout=0; Issue_count=1.
- Push pairs 32'hC0300000+32'h40B00000, then 32'h40300000+32'hC0B00000, back-to-back -> results 32'h40300000 then 32'hC0300000 in order; Data_valid low between issues until Dataout_valid drops.
- DEPTH=4, Res_ready=0, push 5 pairs with a responder model -> 1st issued; Op_ready low once 4 entries are held; no 2nd issue while Res_valid=1; raising Res_ready drains all 5 in order.
- Responder holds Dataout_valid high at idle -> no issue until it drops; then issue within 1 cycle.
- With the macro, TIMEOUT_CYCLES=8, responder silent -> after 8 cycles in WAIT_RESP: Res_data=32'h7FC00000, Res_timeout=1, Data_valid=0.
- Assert RST for 1 cycle while in WAIT_RESP with 2 entries queued -> next cycle: Data_valid=0, Busy=0, Op_ready=1, Issue_count=0, Res_valid=0.
